// File: rtl/gshare_pht.sv
// gshare branch direction predictor: a table of saturating counters indexed by
// PC bits XOR global history, with a registered predict port and a separate
// training port that also shifts the global history register.
// Optional statistics counters are built when GSHARE_PHT_STATS_EN is defined.
module gshare_pht #(
    parameter int unsigned IDX_BITS  = 8,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned HIST_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pred_req,
    input  logic [IDX_BITS-1:0] pred_addr,
    output logic                pred_valid,
    output logic                pred_taken,
    output logic [IDX_BITS-1:0] pred_idx,
    input  logic                upd_valid,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken
`ifdef GSHARE_PHT_STATS_EN
    ,
    input  logic                stat_clr,
    output logic [15:0]         stat_upd_cnt,
    output logic [15:0]         stat_mispred_cnt
`endif
);

    localparam int unsigned DEPTH = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    logic [CTR_BITS-1:0]  ctr_q [DEPTH];
    logic [HIST_BITS-1:0] ghr_q;
    logic [IDX_BITS-1:0]  hash_idx_c;
    logic [CTR_BITS-1:0]  upd_old_c;
    logic [CTR_BITS-1:0]  upd_new_c;

    // gshare hash: PC bits XOR zero-extended history
    assign hash_idx_c = pred_addr ^ IDX_BITS'(ghr_q);

    // Saturating increment/decrement of the entry being trained
    always_comb begin
        upd_old_c = ctr_q[upd_idx];
        upd_new_c = upd_old_c;
        if (upd_taken) begin
            if (upd_old_c != CTR_MAX) upd_new_c = upd_old_c + CTR_BITS'(1);
        end else begin
            if (upd_old_c != '0) upd_new_c = upd_old_c - CTR_BITS'(1);
        end
    end

    // Counter table; reads elsewhere see pre-update values in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
        end else if (upd_valid) begin
            ctr_q[upd_idx] <= upd_new_c;
        end
    end

    // Non-speculative global history, shifted in at resolve time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else if (upd_valid) begin
            ghr_q <= HIST_BITS'({ghr_q, upd_taken});
        end
    end

    // Registered prediction; taken/idx hold when no request is made
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_idx   <= '0;
        end else begin
            pred_valid <= pred_req;
            if (pred_req) begin
                pred_idx   <= hash_idx_c;
                pred_taken <= ctr_q[hash_idx_c][CTR_BITS-1];
            end
        end
    end

`ifdef GSHARE_PHT_STATS_EN
    logic mispred_c;

    // A misprediction is judged against the counter state before training
    assign mispred_c = upd_old_c[CTR_BITS-1] != upd_taken;

    // Saturating update and mispredict counters; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_upd_cnt     <= '0;
            stat_mispred_cnt <= '0;
        end else if (stat_clr) begin
            stat_upd_cnt     <= '0;
            stat_mispred_cnt <= '0;
        end else if (upd_valid) begin
            if (stat_upd_cnt != 16'hFFFF) stat_upd_cnt <= stat_upd_cnt + 16'd1;
            if (mispred_c && (stat_mispred_cnt != 16'hFFFF))
                stat_mispred_cnt <= stat_mispred_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
- Parametrised successor to the flat per-entry predictor table.
- Holds 2^IDX_BITS saturating counters of CTR_BITS each, plus a global history register (GHR).
- Predict index is PC bits XOR history (gshare hash). Prediction output is registered.
- Separate update port trains the counters and shifts the GHR. Sits between fetch (predict) and branch-resolve (update).

Parameters:
- IDX_BITS, 8, table index width; table depth = 2^IDX_BITS entries.
- CTR_BITS, 2, counter width per entry; legal range 1..4.
- HIST_BITS, 4, GHR length; legal range 1..IDX_BITS. GHR is zero-extended to IDX_BITS before the XOR.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pred_req  in  1  predict request strobe.
- pred_addr  in  IDX_BITS  branch PC index bits.
- pred_valid  out  1  registered; high the cycle after pred_req.
- pred_taken  out  1  registered prediction, = MSB of the selected counter.
- pred_idx  out  IDX_BITS  registered hashed index. Caller returns it on upd_idx.
- upd_valid  in  1  update strobe.
- upd_idx  in  IDX_BITS  entry to train (the pred_idx value captured at predict time).
- upd_taken  in  1  resolved direction.

Behaviour:
- Reset, asynchronous on rst_n low:
  - every counter = 2^(CTR_BITS-1)-1 (weakly not-taken; 1 for CTR_BITS=2);
  - GHR = 0;
  - pred_valid = 0, pred_taken = 0, pred_idx = 0.
  - Any in-flight prediction is discarded.
- Predict:
  - pred_req=1 in cycle N: idx = pred_addr ^ {0, GHR}.
  - Cycle N+1: pred_valid=1, pred_idx=idx, pred_taken = MSB(counter[idx]), read with cycle-N values.
  - pred_req=0: pred_valid=0 next cycle; pred_taken and pred_idx hold their last values.
  - Latency is 1; back-to-back requests are accepted every cycle.
- Update:
  - upd_valid=1 in cycle N: counter[upd_idx] increments if upd_taken=1, else decrements.
  - Saturates at 2^CTR_BITS-1 and at 0; no wrap.
  - GHR <= {GHR[HIST_BITS-2:0], upd_taken}. For HIST_BITS=1, GHR <= upd_taken.
  - The GHR is non-speculative; there is no repair path.
- Simultaneous predict and update in the same cycle:
  - The predict uses the pre-update counter and pre-update GHR, including when the indices match.
  - The new values are visible to requests from cycle N+1 onward.
- Only one update per cycle. No stall or backpressure: both ports are always ready.
- No X propagation: all index arithmetic is modulo 2^IDX_BITS.

Optional Feature:
- Macro: GSHARE_PHT_STATS_EN.
- Defined — adds ports:
  - stat_clr  in  1: synchronous clear of both counters.
  - stat_upd_cnt  out  16: count of upd_valid cycles.
  - stat_mispred_cnt  out  16: count of updates where MSB(counter[upd_idx]) before the update != upd_taken.
- Both counters saturate at 0xFFFF and reset to 0 on rst_n.
- stat_clr has priority over an increment in the same cycle.
- Undefined — the three ports and all stats logic are absent; behaviour is otherwise identical.

Test Plan (IDX_BITS=8, CTR_BITS=2, HIST_BITS=4):
1. Reset release, pred_req with pred_addr=0x00 -> next cycle pred_valid=1, pred_taken=0, pred_idx=0x00. With no request the following cycle, pred_valid=0.
2. Two taken updates on upd_idx=0x05:
   - counter[0x05] goes 1->2->3; GHR goes 0x0->0x1->0x3.
   - Then pred_addr=0x06 -> pred_idx=0x05, pred_taken=1.
3. Saturation on idx 0x10:
   - four taken updates -> counter stays 3;
   - one not-taken -> 2, predicts taken;
   - second not-taken -> 1, predicts not-taken;
   - two more not-taken -> holds 0.
4. Collision:
   - Setup: GHR=0, counter[0x20]=1.
   - Same cycle: upd_valid idx 0x20 taken=1, and pred_req addr 0x20 -> pred_taken=0.
   - Next request with pred_addr=0x21 (GHR now 0x1, idx 0x20) -> pred_taken=1.
5. Reset mid-stream:
   - Drop rst_n while pred_valid=1 and after training -> pred_valid falls asynchronously, before the next clock.
   - After release, pred_addr=0x05 -> pred_taken=0, pred_idx=0x05.
6. With GSHARE_PHT_STATS_EN defined:
   - 3 updates, one mispredicted -> stat_upd_cnt=3, stat_mispred_cnt=1.
   - stat_clr asserted together with upd_valid -> both counters read 0 next cycle.
   - Preload near 0xFFFF -> counters stick at 0xFFFF.
